mem_op_sequencer: RTL and testbench

//  Command-driven controller sharing one single-port 8x32 RAM and one registered AND/OR unit.
//  Per command: read A and B from RAM, run the op unit, write result C back to RAM.

---
 rtl/mem_op_sequencer.sv | 105 ++++++++++
 tb/tb_mem_op_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_op_sequencer.sv
// Command sequencer: reads operands A/B from a shared single-port RAM, drives a registered
// AND/OR unit, writes the result back to RAM and reports completion.
module mem_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W-1:0] cmd_a_addr,
    input  logic [ADDR_W-1:0] cmd_b_addr,
    input  logic [ADDR_W-1:0] cmd_c_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_mode,
    input  logic [DATA_W-1:0] op_c,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  done_count
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W-1:0] b_addr_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic              mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
            mode_q     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_mode    <= 1'b0;
            result     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_addr_q <= cmd_a_addr;
                        b_addr_q <= cmd_b_addr;
                        c_addr_q <= cmd_c_addr;
                        mode_q   <= cmd_mode;
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    op_a  <= mem_rdata;
                    state <= RD_B;
                end
                RD_B: begin
                    op_b    <= mem_rdata;
                    op_mode <= mode_q;
                    state   <= EXEC;
                end
                EXEC: state <= WB;
                WB: begin
                    result <= op_c;
                    state  <= DONE;
                end
                DONE: begin
                    done_count <= done_count + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port is idle (address 0, no write) in every state that does not access it
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            RD_A: mem_addr = a_addr_q;
            RD_B: mem_addr = b_addr_q;
            WB: begin
                mem_addr  = c_addr_q;
                mem_we    = 1'b1;
                mem_wdata = op_c;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench: two sequencers (CNT_W=8 and CNT_W=2), each with its own RAM and
// registered AND/OR unit model, driven by the same command stream.
module tb_mem_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_mode;
    logic [2:0]  cmd_a_addr, cmd_b_addr, cmd_c_addr;

    logic        cmd_ready0, mem_we0, op_mode0, busy0, done0;
    logic [2:0]  mem_addr0;
    logic [31:0] mem_wdata0, mem_rdata0, op_a0, op_b0, op_c0, result0;
    logic [7:0]  done_count0;

    logic        cmd_ready1, mem_we1, op_mode1, busy1, done1;
    logic [2:0]  mem_addr1;
    logic [31:0] mem_wdata1, mem_rdata1, op_a1, op_b1, op_c1, result1;
    logic [1:0]  done_count1;

    logic [31:0] ram0 [8];
    logic [31:0] ram1 [8];
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;

    int nerr = 0;
    int nchecks = 0;

    always #5 clk = ~clk;

    mem_op_sequencer #(.DATA_W(32), .ADDR_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_mode(cmd_mode), .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
        .cmd_c_addr(cmd_c_addr), .mem_addr(mem_addr0), .mem_we(mem_we0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .op_a(op_a0), .op_b(op_b0),
        .op_mode(op_mode0), .op_c(op_c0), .busy(busy0), .done(done0),
        .result(result0), .done_count(done_count0)
    );

    mem_op_sequencer #(.DATA_W(32), .ADDR_W(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_mode(cmd_mode), .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
        .cmd_c_addr(cmd_c_addr), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .op_a(op_a1), .op_b(op_b1),
        .op_mode(op_mode1), .op_c(op_c1), .busy(busy1), .done(done1),
        .result(result1), .done_count(done_count1)
    );

    // RAM models: combinational read, write on posedge; bench preload port shared
    assign mem_rdata0 = ram0[mem_addr0];
    assign mem_rdata1 = ram1[mem_addr1];
    always @(posedge clk) begin
        if (load_en) begin
            ram0[load_addr] <= load_data;
            ram1[load_addr] <= load_data;
        end else begin
            if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
            if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
        end
    end

    // Op unit models: result one cycle after operands are sampled
    always @(posedge clk) begin
        op_c0 <= op_mode0 ? (op_a0 | op_b0) : (op_a0 & op_b0);
        op_c1 <= op_mode1 ? (op_a1 | op_b1) : (op_a1 & op_b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic mode, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_a_addr = a;
        cmd_b_addr = b;
        cmd_c_addr = c;
    endtask

    int hs [3];
    int nhs;
    int ndone;
    logic [1:0] small_seq [3];
    logic prev_done;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0;
        cmd_a_addr = '0; cmd_b_addr = '0; cmd_c_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        step(); step();
        rst = 1'b0;

        // 1: reset / idle state
        chk("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_mem_we", 32'(mem_we0), 32'd0);
        chk("rst_done_count", 32'(done_count0), 32'd0);
        chk("rst_result", result0, 32'd0);

        // Preload RAM (sequencer idle, cmd_valid low)
        load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_addr = 3'(i);
            load_data = (i == 1) ? 32'hF0F0_FFFF :
                        (i == 2) ? 32'h0FF0_00FF : 32'h1111_1111 * 32'(i);
            step();
        end
        load_en = 1'b0;

        // 2: AND a=1 b=2 c=3, cycle-by-cycle
        issue(1'b0, 3'd1, 3'd2, 3'd3);
        step();                                   // T+1 RD_A
        cmd_valid = 1'b0;
        chk("t2_busy_rda", 32'(busy0), 32'd1);
        chk("t2_ready_rda", 32'(cmd_ready0), 32'd0);
        chk("t2_addr_rda", 32'(mem_addr0), 32'd1);
        step();                                   // T+2 RD_B
        chk("t2_addr_rdb", 32'(mem_addr0), 32'd2);
        chk("t2_op_a", op_a0, 32'hF0F0_FFFF);
        step();                                   // T+3 EXEC
        chk("t2_op_b", op_b0, 32'h0FF0_00FF);
        chk("t2_op_mode", 32'(op_mode0), 32'd0);
        chk("t2_addr_exec", 32'(mem_addr0), 32'd0);
        chk("t2_we_exec", 32'(mem_we0), 32'd0);
        step();                                   // T+4 WB
        chk("t2_we_wb", 32'(mem_we0), 32'd1);
        chk("t2_addr_wb", 32'(mem_addr0), 32'd3);
        chk("t2_wdata_wb", mem_wdata0, 32'h00F0_00FF);
        chk("t2_done_wb", 32'(done0), 32'd0);
        step();                                   // T+5 DONE
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_result", result0, 32'h00F0_00FF);
        chk("t2_wdata_done", mem_wdata0, 32'd0);
        step();                                   // back to IDLE
        chk("t2_done_clr", 32'(done0), 32'd0);
        chk("t2_ram3", ram0[3], 32'h00F0_00FF);
        chk("t2_done_count", 32'(done_count0), 32'd1);
        chk("t2_small_count", 32'(done_count1), 32'd1);

        // 3: OR with C aliasing A
        issue(1'b1, 3'd1, 3'd2, 3'd1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t3_ram1", ram0[1], 32'hFFF0_FFFF);
        chk("t3_ram2", ram0[2], 32'h0FF0_00FF);
        chk("t3_result", result0, 32'hFFF0_FFFF);
        chk("t3_done_count", 32'(done_count0), 32'd2);
        chk("t3_small_count", 32'(done_count1), 32'd2);

        // 4: cmd_valid held high, three back-to-back AND a=3 b=1 c=4
        issue(1'b0, 3'd3, 3'd1, 3'd4);
        nhs = 0; ndone = 0; prev_done = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (prev_done && ndone <= 3) small_seq[ndone-1] = done_count1;
            prev_done = done0;
            if (done0) ndone++;
            if (cmd_valid && cmd_ready0) begin
                if (nhs < 3) hs[nhs] = i;
                nhs++;
            end
            step();
            if (nhs == 3) cmd_valid = 1'b0;
        end
        chk("t4_handshakes", 32'(nhs), 32'd3);
        chk("t4_gap1", 32'(hs[1] - hs[0]), 32'd6);
        chk("t4_gap2", 32'(hs[2] - hs[1]), 32'd6);
        chk("t4_dones", 32'(ndone), 32'd3);
        chk("t4_ram4", ram0[4], 32'h00F0_00FF);
        chk("t4_done_count", 32'(done_count0), 32'd5);

        // 6: CNT_W=2 counter across the five completions: ...,3,0,1
        chk("t6_small_c3", 32'(small_seq[0]), 32'd3);
        chk("t6_small_c4", 32'(small_seq[1]), 32'd0);
        chk("t6_small_c5", 32'(small_seq[2]), 32'd1);

        // 5: reset during EXEC drops the command
        issue(1'b1, 3'd1, 3'd2, 3'd6);
        step();
        cmd_valid = 1'b0;
        step(); step();                           // now in EXEC
        chk("t5_exec_we", 32'(mem_we0), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_ready", 32'(cmd_ready0), 32'd1);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_op_a", op_a0, 32'd0);
        chk("t5_result", result0, 32'd0);
        chk("t5_done_count", 32'(done_count0), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done0 || mem_we0) ndone++;
            step();
        end
        chk("t5_no_done_or_write", 32'(ndone), 32'd0);
        chk("t5_ram6", ram0[6], 32'h6666_6666);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
